// File: rtl/tile_map_server_pkg.sv
// Shared map dimensions, FSM state, write-entry type and the power-up row pattern.
// Optional macro TILE_MAP_DEFAULT_LAYOUT_EN adds two interior obstacle columns to the rebuilt map.
package tile_map_server_pkg;

  localparam int WIDTH             = 64;
  localparam int GAME_HEIGHT       = 44;
  localparam int STATUS_BAR_HEIGHT = 4;

  typedef enum logic {
    INIT  = 1'b0,
    SERVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic       data;
  } wr_entry_t;

  // Contents of one freshly rebuilt map row: solid border, open interior.
  function automatic logic [WIDTH-1:0] init_row(input logic [5:0] y);
    logic [WIDTH-1:0] row_s;
    if (y == 6'd0 || y == 6'(GAME_HEIGHT - 1)) begin
      row_s = '1;
    end else begin
      row_s            = '0;
      row_s[0]         = 1'b1;
      row_s[WIDTH - 1] = 1'b1;
`ifdef TILE_MAP_DEFAULT_LAYOUT_EN
      if (y >= 6'd10 && y <= 6'd33) begin
        row_s[16] = 1'b1;
        row_s[47] = 1'b1;
      end
`endif
    end
    return row_s;
  endfunction

endpackage

// File: rtl/tile_map_server_if.sv
// Scanner request, collision query, map-write and init signals of the tile map server.
interface tile_map_server_if;
  logic [5:0] i_request_x;
  logic [5:0] i_request_y;
  logic       i_buzy;
  logic       o_is_wall;
  logic [5:0] i_query_x;
  logic [5:0] i_query_y;
  logic       o_query_wall;
  logic       i_wr_valid;
  logic [5:0] i_wr_x;
  logic [5:0] i_wr_y;
  logic       i_wr_data;
  logic       o_wr_ready;
  logic       i_init;
  logic       o_init_done;

  modport master (
    output i_request_x, i_request_y, i_buzy, i_query_x, i_query_y,
    output i_wr_valid, i_wr_x, i_wr_y, i_wr_data, i_init,
    input  o_is_wall, o_query_wall, o_wr_ready, o_init_done
  );

  modport slave (
    input  i_request_x, i_request_y, i_buzy, i_query_x, i_query_y,
    input  i_wr_valid, i_wr_x, i_wr_y, i_wr_data, i_init,
    output o_is_wall, o_query_wall, o_wr_ready, o_init_done
  );
endinterface

// File: rtl/tile_map_server_write_fifo.sv
// In-order buffer of pending map writes; flush discards everything held.
module tile_write_fifo
  import tile_map_server_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  wr_entry_t              din,
  output wr_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wr_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against occupancy.
  always_comb begin
    push_ok_s = push && (count_r != CNT_W'(DEPTH));
    pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(push_ok_s);
      rd_ptr_r <= rd_ptr_r + PTR_W'(pop_ok_s);
      count_r  <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/tile_map_server.sv
// Wall map server: rebuilds the map, answers scanner/collision reads, defers writes while the scanner is busy.
// Build option: TILE_MAP_DEFAULT_LAYOUT_EN (obstacle columns in the rebuilt map).
module tile_map_server
  import tile_map_server_pkg::*;
#(
  parameter int WR_FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  tile_map_server_if.slave bus
);
  localparam int         CNT_W    = $clog2(WR_FIFO_DEPTH) + 1;
  localparam logic [5:0] LAST_ROW = 6'(GAME_HEIGHT - 1);
  localparam logic [5:0] MAP_ROWS = 6'(GAME_HEIGHT);
  localparam logic [5:0] LAST_COL = 6'(WIDTH - 1);

  logic [WIDTH-1:0] map_r [GAME_HEIGHT];
  state_t           state_r;
  state_t           state_next_s;
  logic [5:0]       row_r;
  logic             init_done_r;
  logic             wr_ready_r;
  logic             is_wall_r;
  logic             query_wall_r;
  logic             push_s;
  logic             pop_s;
  logic             commit_s;
  logic             init_wr_s;
  logic             ready_next_s;
  logic             req_wall_s;
  logic             qry_wall_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] count_next_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  wr_entry_t        wr_entry_s;
  wr_entry_t        head_s;

  // Handshake, commit qualification and next-state decode.
  always_comb begin
    wr_entry_s   = '{x: bus.i_wr_x, y: bus.i_wr_y, data: bus.i_wr_data};
    push_s       = bus.i_wr_valid && wr_ready_r && !bus.i_init;
    pop_s        = (state_r == SERVE) && !bus.i_buzy && !fifo_empty_s && !bus.i_init;
    init_wr_s    = (state_r == INIT) && !bus.i_init;
    // Off-field rows and border tiles are consumed but never change the map.
    commit_s     = pop_s && (head_s.y < MAP_ROWS) && (head_s.y != 6'd0) && (head_s.y != LAST_ROW)
                   && (head_s.x != 6'd0) && (head_s.x != LAST_COL);
    count_next_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    if (bus.i_init) begin
      state_next_s = INIT;
    end else begin
      case (state_r)
        INIT:    state_next_s = (row_r == LAST_ROW) ? SERVE : INIT;
        SERVE:   state_next_s = SERVE;
        default: state_next_s = INIT;
      endcase
    end
    ready_next_s = (state_next_s == SERVE) && (count_next_s < CNT_W'(WR_FIFO_DEPTH)) && !bus.i_init;
  end

  // Map lookups; rows below the field read as wall.
  always_comb begin
    if (bus.i_request_y >= MAP_ROWS) begin
      req_wall_s = 1'b1;
    end else begin
      req_wall_s = map_r[bus.i_request_y][bus.i_request_x];
    end
    if (bus.i_query_y >= MAP_ROWS) begin
      qry_wall_s = 1'b1;
    end else begin
      qry_wall_s = map_r[bus.i_query_y][bus.i_query_x];
    end
  end

  // Map storage: whole-row rebuild during INIT, single-tile commits during SERVE.
  always_ff @(posedge clk) begin
    if (init_wr_s) begin
      map_r[row_r] <= init_row(row_r);
    end else if (commit_s) begin
      map_r[head_s.y][head_s.x] <= head_s.data;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= INIT;
      row_r        <= 6'd0;
      init_done_r  <= 1'b0;
      wr_ready_r   <= 1'b0;
      is_wall_r    <= 1'b0;
      query_wall_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      wr_ready_r <= ready_next_s;
      if (bus.i_init) begin
        row_r       <= 6'd0;
        init_done_r <= 1'b0;
      end else if (state_r == INIT) begin
        row_r       <= (row_r == LAST_ROW) ? 6'd0 : row_r + 6'd1;
        init_done_r <= (row_r == LAST_ROW);
      end
      is_wall_r    <= (state_r == SERVE) ? req_wall_s : 1'b0;
      query_wall_r <= (state_r == SERVE) ? qry_wall_s : 1'b0;
    end
  end

  tile_write_fifo #(
    .DEPTH (WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.i_init),
    .push  (push_s),
    .pop   (pop_s),
    .din   (wr_entry_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count_s)
  );

  assign bus.o_is_wall    = is_wall_r;
  assign bus.o_query_wall = query_wall_r;
  assign bus.o_wr_ready   = wr_ready_r;
  assign bus.o_init_done  = init_done_r;

endmodule

// File: tb/tb_tile_map_server.sv
// Directed bench for tile_map_server: rebuild timing, reads, buffered writes, FIFO full, border, restart, layout.
module tb_tile_map_server;
  import tile_map_server_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  tile_map_server_if bus();

  tile_map_server #(.WR_FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_tile(input logic [5:0] x, input logic [5:0] y, output logic w, output logic q);
    bus.i_request_x = x;
    bus.i_request_y = y;
    bus.i_query_x   = x;
    bus.i_query_y   = y;
    tick();
    w = bus.o_is_wall;
    q = bus.o_query_wall;
  endtask

  task automatic write_tile(input logic [5:0] x, input logic [5:0] y, input logic d);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_x     = x;
    bus.i_wr_y     = y;
    bus.i_wr_data  = d;
    tick();
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    bus.i_request_x = 6'd0; bus.i_request_y = 6'd0; bus.i_query_x = 6'd0; bus.i_query_y = 6'd0;
    bus.i_buzy = 1'b0; bus.i_wr_valid = 1'b0; bus.i_wr_x = 6'd0; bus.i_wr_y = 6'd0;
    bus.i_wr_data = 1'b0; bus.i_init = 1'b0;
    tick(); tick();
    total++;
    if ({bus.o_is_wall, bus.o_query_wall, bus.o_wr_ready, bus.o_init_done} !== 4'b0000) begin
      $display("FAIL reset_outputs: got %b want 0000",
               {bus.o_is_wall, bus.o_query_wall, bus.o_wr_ready, bus.o_init_done});
      bad++;
    end
    rst_n = 1'b1;
    cyc = 0;
    while (bus.o_init_done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 10) begin
        total++;
        if ({bus.o_is_wall, bus.o_query_wall, bus.o_wr_ready} !== 3'b000) begin
          $display("FAIL init_outputs_low: got %b want 000", {bus.o_is_wall, bus.o_query_wall, bus.o_wr_ready});
          bad++;
        end
      end
    end
    total++;
    if (cyc !== 44) begin
      $display("FAIL init_duration: got %0d cycles want 44", cyc);
      bad++;
    end
    total++;
    if (bus.o_wr_ready !== 1'b1) begin
      $display("FAIL ready_after_init: got %b want 1", bus.o_wr_ready);
      bad++;
    end
  endtask

  task automatic test_read_ports();
    logic w, q;
    read_tile(6'd0, 6'd5, w, q);
    total++; if ({w, q} !== 2'b11) begin $display("FAIL read_0_5: got %b want 11", {w, q}); bad++; end
    read_tile(6'd5, 6'd5, w, q);
    total++; if ({w, q} !== 2'b00) begin $display("FAIL read_5_5: got %b want 00", {w, q}); bad++; end
    read_tile(6'd5, 6'd44, w, q);
    total++; if ({w, q} !== 2'b11) begin $display("FAIL read_5_44: got %b want 11", {w, q}); bad++; end
    read_tile(6'd63, 6'd20, w, q);
    total++; if ({w, q} !== 2'b11) begin $display("FAIL read_63_20: got %b want 11", {w, q}); bad++; end
    read_tile(6'd20, 6'd43, w, q);
    total++; if ({w, q} !== 2'b11) begin $display("FAIL read_20_43: got %b want 11", {w, q}); bad++; end
  endtask

  task automatic test_buffered_write();
    logic w, q;
    bus.i_buzy = 1'b1;
    total++;
    if (bus.o_wr_ready !== 1'b1) begin $display("FAIL bw_ready: got %b want 1", bus.o_wr_ready); bad++; end
    write_tile(6'd10, 6'd10, 1'b1);
    read_tile(6'd10, 6'd10, w, q);
    read_tile(6'd10, 6'd10, w, q);
    total++; if ({w, q} !== 2'b00) begin $display("FAIL bw_held_while_busy: got %b want 00", {w, q}); bad++; end
    bus.i_buzy = 1'b0;
    read_tile(6'd10, 6'd10, w, q);
    total++; if ({w, q} !== 2'b00) begin $display("FAIL bw_commit_edge_old: got %b want 00", {w, q}); bad++; end
    read_tile(6'd10, 6'd10, w, q);
    total++; if ({w, q} !== 2'b11) begin $display("FAIL bw_after_commit: got %b want 11", {w, q}); bad++; end
  endtask

  task automatic test_fifo_full();
    logic w, q;
    bus.i_buzy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_x     = 6'(20 + i);
      bus.i_wr_y     = 6'd20;
      bus.i_wr_data  = 1'b1;
      total++;
      if (bus.o_wr_ready !== (i < 4)) begin
        $display("FAIL full_ready_%0d: got %b want %b", i, bus.o_wr_ready, (i < 4));
        bad++;
      end
      tick();
    end
    bus.i_wr_valid = 1'b0;
    bus.i_buzy     = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus.i_request_x = 6'(19 + j);
      bus.i_request_y = 6'd20;
      bus.i_query_x   = 6'(20 + j);
      bus.i_query_y   = 6'd20;
      tick();
      total++;
      if ({bus.o_is_wall, bus.o_query_wall} !== {(j > 0), 1'b0}) begin
        $display("FAIL drain_order_%0d: got %b want %b", j, {bus.o_is_wall, bus.o_query_wall}, {(j > 0), 1'b0});
        bad++;
      end
    end
    read_tile(6'd23, 6'd20, w, q);
    total++; if ({w, q} !== 2'b11) begin $display("FAIL drain_last: got %b want 11", {w, q}); bad++; end
    total++;
    if (bus.o_wr_ready !== 1'b1) begin $display("FAIL drain_ready: got %b want 1", bus.o_wr_ready); bad++; end
    read_tile(6'd24, 6'd20, w, q);
    total++; if ({w, q} !== 2'b00) begin $display("FAIL rejected_write: got %b want 00", {w, q}); bad++; end
  endtask

  task automatic test_border();
    logic w, q;
    bus.i_buzy = 1'b0;
    write_tile(6'd0, 6'd3, 1'b0);
    tick(); tick();
    read_tile(6'd0, 6'd3, w, q);
    total++; if ({w, q} !== 2'b11) begin $display("FAIL border_left: got %b want 11", {w, q}); bad++; end
    write_tile(6'd63, 6'd43, 1'b0);
    tick(); tick();
    read_tile(6'd63, 6'd43, w, q);
    total++; if ({w, q} !== 2'b11) begin $display("FAIL border_corner: got %b want 11", {w, q}); bad++; end
    write_tile(6'd10, 6'd10, 1'b0);
    tick(); tick();
    read_tile(6'd10, 6'd10, w, q);
    total++; if ({w, q} !== 2'b00) begin $display("FAIL interior_destroy: got %b want 00", {w, q}); bad++; end
  endtask

  task automatic test_restart();
    logic w, q;
    int   cyc;
    bus.i_buzy = 1'b1;
    write_tile(6'd30, 6'd30, 1'b1);
    write_tile(6'd31, 6'd30, 1'b1);
    bus.i_init = 1'b1;
    tick();
    bus.i_init = 1'b0;
    total++;
    if ({bus.o_init_done, bus.o_wr_ready} !== 2'b00) begin
      $display("FAIL restart_outputs: got %b want 00", {bus.o_init_done, bus.o_wr_ready});
      bad++;
    end
    repeat (20) tick();
    bus.i_init = 1'b1;
    tick();
    bus.i_init = 1'b0;
    cyc = 0;
    while (bus.o_init_done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc !== 44) begin $display("FAIL restart_duration: got %0d cycles want 44", cyc); bad++; end
    bus.i_buzy = 1'b0;
    tick(); tick(); tick();
    read_tile(6'd30, 6'd30, w, q);
    total++; if ({w, q} !== 2'b00) begin $display("FAIL flushed_30: got %b want 00", {w, q}); bad++; end
    read_tile(6'd31, 6'd30, w, q);
    total++; if ({w, q} !== 2'b00) begin $display("FAIL flushed_31: got %b want 00", {w, q}); bad++; end
    read_tile(6'd10, 6'd10, w, q);
    total++; if ({w, q} !== 2'b00) begin $display("FAIL rebuilt_10_10: got %b want 00", {w, q}); bad++; end
  endtask

  task automatic test_layout();
    logic w, q;
`ifdef TILE_MAP_DEFAULT_LAYOUT_EN
    read_tile(6'd16, 6'd10, w, q);
    total++; if ({w, q} !== 2'b11) begin $display("FAIL layout_16_10: got %b want 11", {w, q}); bad++; end
    read_tile(6'd47, 6'd33, w, q);
    total++; if ({w, q} !== 2'b11) begin $display("FAIL layout_47_33: got %b want 11", {w, q}); bad++; end
    read_tile(6'd16, 6'd9, w, q);
    total++; if ({w, q} !== 2'b00) begin $display("FAIL layout_16_9: got %b want 00", {w, q}); bad++; end
    read_tile(6'd17, 6'd20, w, q);
    total++; if ({w, q} !== 2'b00) begin $display("FAIL layout_17_20: got %b want 00", {w, q}); bad++; end
`else
    read_tile(6'd16, 6'd10, w, q);
    total++; if ({w, q} !== 2'b00) begin $display("FAIL open_16_10: got %b want 00", {w, q}); bad++; end
    read_tile(6'd47, 6'd33, w, q);
    total++; if ({w, q} !== 2'b00) begin $display("FAIL open_47_33: got %b want 00", {w, q}); bad++; end
`endif
  endtask

  initial begin
    test_reset();
    test_read_ports();
    test_buffered_write();
    test_fifo_full();
    test_border();
    test_restart();
    test_layout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_map_server.md
Name: tile_map_server

Overview:
- Game-side responder to the VGA tile-request interface. It holds the wall map for the game field and answers the display scanner's per-tile requests with a wall bit.
- It also serves a collision-query port for tank/shell logic.
- It buffers map writes (wall destruction) and commits them only while the scanner is not busy, so the display never sees a half-updated frame region.
- It sits between the game logic and the VGA block.

Parameters:
- WIDTH, 64, map columns (tiles per row).
- GAME_HEIGHT, 44, map rows (field rows below the status bar).
- WR_FIFO_DEPTH, 4, pending-write buffer entries (power of two).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- i_request_x  input  6  tile column requested by the scanner.
- i_request_y  input  6  tile row requested by the scanner.
- i_buzy  input  1  scanner is in active display lines; map writes must wait.
- o_is_wall  output  1  wall bit for the registered request.
- i_query_x  input  6  collision query column.
- i_query_y  input  6  collision query row.
- o_query_wall  output  1  wall bit for the registered query.
- i_wr_valid  input  1  write request.
- i_wr_x  input  6  write column.
- i_wr_y  input  6  write row.
- i_wr_data  input  1  new wall bit (0 = destroy, 1 = build).
- o_wr_ready  output  1  write accepted when valid&&ready.
- i_init  input  1  pulse: rebuild map.
- o_init_done  output  1  map valid, serving.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: o_is_wall=0, o_query_wall=0, o_wr_ready=0, o_init_done=0, FIFO empty, state=INIT, row counter=0.
- Storage: GAME_HEIGHT rows × WIDTH bits, flop array, row-indexed.
- FSM states:
  - INIT: writes one full row per cycle (row counter 0..GAME_HEIGHT-1). Border tiles (x=0, x=WIDTH-1, y=0, y=GAME_HEIGHT-1) are 1; interior is 0.
  - INIT → SERVE after the last row, so INIT lasts exactly GAME_HEIGHT cycles.
  - i_init in any state (including mid-INIT) restarts INIT at row 0 and flushes the FIFO.
- o_init_done:
  - 0 in INIT.
  - Rises the cycle after the last INIT row is written.
- Read ports:
  - Both ports have 1-cycle latency: output registered from the map as it stands at the sampling edge.
  - Row ≥ GAME_HEIGHT returns 1 (treated as wall).
  - During INIT both outputs are 0.
- Read/write collision: a read and a commit to the same tile in the same cycle return the old value.
- Write accept:
  - o_wr_ready = (state==SERVE) && FIFO not full; registered, so no same-cycle full bypass.
  - Accepted writes are enqueued in order.
- Write commit:
  - In SERVE, when !i_buzy and FIFO not empty, the head entry is committed and dequeued; one commit per cycle.
  - With i_buzy=1, entries wait indefinitely.
- Enqueue and dequeue in the same cycle are both allowed; occupancy is unchanged.
- Dropped writes: writes with y ≥ GAME_HEIGHT, and writes to border tiles, are accepted but dropped at commit (border protected).
- Occupancy counter width is log2(WR_FIFO_DEPTH)+1; pointers wrap modulo depth.

Optional Feature:
- Macro: TILE_MAP_DEFAULT_LAYOUT_EN.
- When defined, INIT additionally sets interior obstacle columns x=16 and x=47 for rows 10..33 inclusive to 1.
- When undefined, the interior is all 0.
- Border behaviour is identical in both cases.

Decomposition:
- Shared package holds:
  - map dimension constants: WIDTH, GAME_HEIGHT, STATUS_BAR_HEIGHT;
  - FSM state enum {INIT, SERVE};
  - write-entry struct {x[5:0], y[5:0], data}.
- One sub-module: tile_write_fifo (synchronous FIFO of write-entry structs, depth WR_FIFO_DEPTH, push/pop/full/empty).

Test Plan:
- Reset release, no stimulus:
  - o_init_done rises after 44 cycles;
  - request (0,5) → o_is_wall=1 one cycle later;
  - request (5,5) → 0;
  - request (5,44) → 1.
- Buffered write:
  - i_buzy=1, write (10,10,1) → accepted; o_is_wall stays 0 for (10,10) while busy.
  - Drop i_buzy → (10,10) reads 1 on the cycle after the commit.
- FIFO full:
  - i_buzy=1, offer 5 writes back-to-back → 4 accepted, o_wr_ready=0 on the 5th.
  - Release i_buzy → 4 commits in 4 cycles, in order; ready returns 1.
- Border protection: write (0,3,0) with i_buzy=0 → (0,3) still reads 1.
- Mid-INIT restart:
  - Pulse i_init at INIT row 20 → o_init_done delayed until 44 cycles after the pulse.
  - Pending FIFO entries are discarded.
- TILE_MAP_DEFAULT_LAYOUT_EN defined:
  - (16,10) and (47,33) read 1; (16,9) and (17,20) read 0.
  - Without the macro, (16,10) reads 0.
